// File: rtl/ram_param_if.sv
// ram_param_if: access/fill bus for ram_param.
//   master : drives en, r_w, addr, in1, fill, fill_data; observes out1,
//            out_valid, busy, ready
//   slave  : the RAM side of the same signals
interface ram_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              en;
  logic              r_w;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  in1;
  logic [WIDTH-1:0]  out1;
  logic              out_valid;
  logic              fill;
  logic [WIDTH-1:0]  fill_data;
  logic              busy;
  logic              ready;

  modport master (
    output en, r_w, addr, in1, fill, fill_data,
    input  out1, out_valid, busy, ready
  );

  modport slave (
    input  en, r_w, addr, in1, fill, fill_data,
    output out1, out_valid, busy, ready
  );
endinterface

// File: rtl/ram_param.sv
// ram_param: WIDTH x DEPTH single-port synchronous RAM with a registered
// read (plus one-cycle valid pulse), async whole-array clear and a fill
// engine that writes one captured constant to every word, one per cycle.
// Ports:
//   clk   : clock, all state changes on the rising edge except clear
//   clear : asynchronous active-low reset, zeroes the array
//   bus   : ram_param_if.slave (en, r_w, addr, in1, out1, out_valid,
//           fill, fill_data, busy, ready)
//
// state  | meaning
// IDLE   | accepts reads, writes and fill requests; ready=1
// FILL   | writing r_fill_val to r_fill_cnt each cycle; busy=1
module ram_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        clear,
  ram_param_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [WIDTH-1:0]  r_fill_val;
  logic [WIDTH-1:0]  r_out1;
  logic              r_out_valid;

  logic w_idle;
  logic w_in_range;

  assign w_idle     = (r_state == S_IDLE);
  // Only matters for non-power-of-2 DEPTH; otherwise always true.
  assign w_in_range = ({1'b0, bus.addr} < DEPTH_W);

  assign bus.out1      = r_out1;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = ~w_idle;
  assign bus.ready     = w_idle;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state     <= S_IDLE;
      r_fill_cnt  <= '0;
      r_fill_val  <= '0;
      r_out1      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        // fill wins over a simultaneous access; the access is dropped
        if (bus.fill) begin
          r_state    <= S_FILL;
          r_fill_cnt <= '0;
          r_fill_val <= bus.fill_data;
        end else if (bus.en && bus.r_w) begin
          if (w_in_range) r_mem[bus.addr] <= bus.in1;
        end else if (bus.en) begin
          r_out_valid <= 1'b1;
          r_out1      <= w_in_range ? r_mem[bus.addr] : '0;
        end
      end else begin
        r_mem[r_fill_cnt] <= r_fill_val;
        if (r_fill_cnt == LAST_ADDR) begin
          r_state    <= S_IDLE;
          r_fill_cnt <= '0;
        end else begin
          r_fill_cnt <= r_fill_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_param.sv
module tb_ram_param;
  logic clk;
  logic clear;

  ram_param_if #(.WIDTH(4), .DEPTH(8)) ifa ();
  ram_param_if #(.WIDTH(4), .DEPTH(6)) ifb ();

  ram_param #(.WIDTH(4), .DEPTH(8)) dut_a (.clk(clk), .clear(clear), .bus(ifa));
  ram_param #(.WIDTH(4), .DEPTH(6)) dut_b (.clk(clk), .clear(clear), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] mdl_a [8];
  logic [3:0] mdl_b [6];
  logic [3:0] sbq [$];

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit en, input bit rw, input logic [2:0] a,
                       input logic [3:0] d);
    @(negedge clk);
    ifa.fill = 1'b0; ifb.fill = 1'b0;
    ifa.en = 1'b0;   ifb.en = 1'b0;
    if (!sel) begin
      ifa.en = en; ifa.r_w = rw; ifa.addr = a; ifa.in1 = d;
    end else begin
      ifb.en = en; ifb.r_w = rw; ifb.addr = a; ifb.in1 = d;
    end
    @(posedge clk); #1;
    ifa.en = 1'b0; ifb.en = 1'b0;
  endtask

  task automatic do_write(input bit sel, input logic [2:0] a, input logic [3:0] d);
    drive(sel, 1'b1, 1'b1, a, d);
    if (!sel) mdl_a[a] = d;
    else if (a < 3'd6) mdl_b[a] = d;
    chk("wr_no_valid", {31'b0, sel ? ifb.out_valid : ifa.out_valid}, 32'd0);
  endtask

  task automatic do_read(input bit sel, input logic [2:0] a, input string tag);
    logic       ov;
    logic [3:0] o1;
    logic [3:0] e;
    if (!sel) sbq.push_back(mdl_a[a]);
    else sbq.push_back((a < 3'd6) ? mdl_b[a] : 4'h0);
    drive(sel, 1'b1, 1'b0, a, 4'h0);
    ov = sel ? ifb.out_valid : ifa.out_valid;
    o1 = sel ? ifb.out1 : ifa.out1;
    chk({tag, "_valid"}, {31'b0, ov}, 32'd1);
    e = sbq.pop_front();
    if (ov) chk(tag, {28'b0, o1}, {28'b0, e});
  endtask

  initial begin
    int bcnt;
    int ovbad;
    int rdbad;
    clear = 1'b0;
    ifa.en = 0; ifa.r_w = 0; ifa.addr = 0; ifa.in1 = 0; ifa.fill = 0; ifa.fill_data = 0;
    ifb.en = 0; ifb.r_w = 0; ifb.addr = 0; ifb.in1 = 0; ifb.fill = 0; ifb.fill_data = 0;
    for (int i = 0; i < 8; i++) mdl_a[i] = 4'h0;
    for (int i = 0; i < 6; i++) mdl_b[i] = 4'h0;

    // 1: reset state, then read every address with idle gaps
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  {31'b0, ifa.busy},      32'd0);
    chk("rst_ready", {31'b0, ifa.ready},     32'd1);
    chk("rst_valid", {31'b0, ifa.out_valid}, 32'd0);
    chk("rst_out1",  {28'b0, ifa.out1},      32'd0);
    @(negedge clk);
    clear = 1'b1;
    for (int a = 0; a < 8; a++) begin
      do_read(1'b0, 3'(a), "rst_rd");
      drive(1'b0, 1'b0, 1'b0, 3'd0, 4'h0);
      chk("gap_valid", {31'b0, ifa.out_valid}, 32'd0);
    end

    // 2: write then read back-to-back, neighbour untouched
    do_write(1'b0, 3'd3, 4'hA);
    do_read(1'b0, 3'd3, "wr_rd3");
    do_read(1'b0, 3'd2, "rd2");

    // 3: fill over a pre-written array, fill_data changes mid-fill
    for (int a = 0; a < 8; a++) do_write(1'b0, 3'(a), 4'h5);
    @(negedge clk);
    ifa.fill = 1'b1; ifa.fill_data = 4'hC;
    @(posedge clk); #1;
    chk("fill_busy",  {31'b0, ifa.busy},  32'd1);
    chk("fill_ready", {31'b0, ifa.ready}, 32'd0);
    bcnt = 0; ovbad = 0; rdbad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ifa.fill = 1'b0;
      if (i == 1) ifa.fill_data = 4'h3;
      if (ifa.busy) bcnt++;
      if (ifa.out_valid) ovbad++;
      if (ifa.ready === ifa.busy) rdbad++;
    end
    chk("fill_cycles", 32'(bcnt), 32'd8);
    chk("fill_ovalid", 32'(ovbad), 32'd0);
    chk("ready_nbusy", 32'(rdbad), 32'd0);
    for (int a = 0; a < 8; a++) mdl_a[a] = 4'hC;
    for (int a = 0; a < 8; a++) do_read(1'b0, 3'(a), "fillC");

    // 4: fill with simultaneous read, then accesses while busy
    @(negedge clk);
    ifa.fill = 1'b1; ifa.fill_data = 4'h6;
    ifa.en = 1'b1; ifa.r_w = 1'b0; ifa.addr = 3'd0;
    @(posedge clk); #1;
    chk("fill_drop_valid", {31'b0, ifa.out_valid}, 32'd0);
    bcnt = 0; ovbad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ifa.fill = 1'b0;
      ifa.en   = (i == 2 || i == 3);
      ifa.r_w  = (i == 2);
      ifa.addr = 3'd1;
      ifa.in1  = 4'hF;
      if (ifa.busy) bcnt++;
      if (ifa.out_valid) ovbad++;
    end
    ifa.en = 1'b0;
    chk("busy_cycles2", 32'(bcnt), 32'd8);
    chk("busy_ovalid",  32'(ovbad), 32'd0);
    chk("busy_out1_hold", {28'b0, ifa.out1}, 32'hC);
    for (int a = 0; a < 8; a++) mdl_a[a] = 4'h6;
    do_read(1'b0, 3'd1, "busy_wr_ignored");
    do_read(1'b0, 3'd5, "fill6");

    // 5: async clear during the 4th fill cycle
    @(negedge clk);
    ifa.fill = 1'b1; ifa.fill_data = 4'hA;
    @(posedge clk); #1;
    @(negedge clk);
    ifa.fill = 1'b0;
    repeat (3) @(posedge clk);
    #3 clear = 1'b0;
    #1;
    chk("clr_busy",  {31'b0, ifa.busy},      32'd0);
    chk("clr_ready", {31'b0, ifa.ready},     32'd1);
    chk("clr_valid", {31'b0, ifa.out_valid}, 32'd0);
    chk("clr_out1",  {28'b0, ifa.out1},      32'd0);
    @(negedge clk);
    clear = 1'b1;
    for (int a = 0; a < 8; a++) mdl_a[a] = 4'h0;
    for (int a = 0; a < 8; a++) do_read(1'b0, 3'(a), "clr_rd");

    // 6: DEPTH=6 instance, out-of-range write/read
    for (int a = 0; a < 6; a++) do_write(1'b1, 3'(a), 4'(a + 1));
    do_write(1'b1, 3'd7, 4'h9);
    do_read(1'b1, 3'd7, "oor_rd7");
    do_read(1'b1, 3'd6, "oor_rd6");
    for (int a = 0; a < 6; a++) do_read(1'b1, 3'(a), "b_rd");

    chk("sbq_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
